hmc_link_init_ctrl: RTL and testbench
=====================================

Name: hmc_link_init_ctrl

Overview:
Sequences HMC link bring-up on the memory-model side of the transceiver/HMC pin interface. It drives P_RST_N, LXRXPS, phy_init_cont_set and the per-lane phy_bit_slip strobes. It monitors PHY readiness, LXTXPS, FERR_N and per-lane alignment status from the descrambler, and reports link_up or init_err to the environment and register file.

Parameters:
NUM_LANES, 16, lane count; width of the slip and alignment vectors
RST_CYCLES, 64, cycles P_RST_N is held low after init_start (min 2)
SLIP_GAP, 16, cycles between successive bit-slip pulse opportunities (min 2)
ALIGN_STABLE, 4, consecutive all-aligned cycles required to declare link up
TIMEOUT, 4096, per-state watchdog limit for WAIT_PHY, WAIT_LXTX and ALIGN

Ports:
hmc_clk  in  1  sole clock
hmc_res  in  1  reset, synchronous, active-high
init_start  in  1  single-cycle request to begin or restart initialisation
phy_tx_ready  in  1  transceiver TX ready
phy_rx_ready  in  1  transceiver RX ready
LXTXPS  in  1  HMC TX power state (1 = powered up)
FERR_N  in  1  HMC fatal error, active-low
lane_aligned  in  NUM_LANES  per-lane alignment flag from the descrambler
P_RST_N  out  1  HMC reset, active-low
LXRXPS  out  1  HMC RX power state request
phy_init_cont_set  out  1  transceiver reset release / init continue
phy_bit_slip  out  NUM_LANES  one-cycle slip pulse per lane
link_up  out  1  link trained and active
init_err  out  1  sticky fatal or timeout indication
init_state  out  3  current state encoding (for the register file and coverage)

Behaviour:
- State encoding: IDLE=0, RST_HOLD=1, WAIT_PHY=2, PWR_UP=3, WAIT_LXTX=4, ALIGN=5, ACTIVE=6, FATAL=7.
- Reset (hmc_res=1 at a clock edge) values: state IDLE; P_RST_N=0, LXRXPS=0, phy_init_cont_set=0, phy_bit_slip=0, link_up=0, init_err=0; all counters cleared.
- Reset mid-operation has the same effect regardless of current state.
- All outputs are registered and change one cycle after the triggering event.
- IDLE: init_start=1 -> RST_HOLD; the hold counter loads RST_CYCLES-1.
- RST_HOLD:
  - P_RST_N stays 0 and the counter decrements.
  - At 0 -> WAIT_PHY; P_RST_N=1 and phy_init_cont_set=1 from the first WAIT_PHY cycle.
  - P_RST_N is therefore low for exactly RST_CYCLES cycles after the init_start cycle.
- WAIT_PHY: phy_tx_ready & phy_rx_ready both 1 in the same cycle -> PWR_UP.
- PWR_UP: one cycle; LXRXPS=1 from the next cycle onward -> WAIT_LXTX.
- WAIT_LXTX: LXTXPS=1 -> ALIGN.
- ALIGN behaviour:
  - The gap counter counts 0..SLIP_GAP-1.
  - On the terminal count, phy_bit_slip[i]=1 for exactly one cycle for every lane i with lane_aligned[i]=0 in that same cycle. Aligned lanes are never slipped.
  - The stable counter increments while lane_aligned is all ones and clears on any zero.
  - Stable counter reaches ALIGN_STABLE -> ACTIVE with link_up=1, and phy_bit_slip is forced to 0.
- ACTIVE:
  - link_up=1 is held.
  - LXTXPS falling to 0, or phy_rx_ready falling to 0 -> FATAL.
  - Loss of lane_aligned is ignored (the link layer handles it).
- Watchdog:
  - Clears on entry to each of WAIT_PHY, WAIT_LXTX and ALIGN.
  - Reaching TIMEOUT cycles in that state -> FATAL.
- FERR_N=0 in any state other than IDLE, RST_HOLD or FATAL -> FATAL.
- Transition priority: FERR_N > ACTIVE drop checks > watchdog > normal transition.
- FATAL:
  - init_err=1 (sticky); P_RST_N=0, LXRXPS=0, phy_init_cont_set=0, link_up=0, phy_bit_slip=0.
  - init_start=1 -> RST_HOLD and clears init_err.
- init_start is ignored in every state except IDLE and FATAL.
- Counters are sized to their parameter (clog2) and must not wrap inside a state.

Test Plan:
- Nominal bring-up (defaults): init_start@0, PHY ready@100, LXTXPS 20 cycles after LXRXPS rises, all lanes aligned@ALIGN entry -> P_RST_N low exactly 64 cycles; link_up=1 four cycles after ALIGN entry plus registration; no phy_bit_slip pulses.
- Lane slipping: lanes 3 and 9 unaligned, each aligning after 2 pulses -> exactly 2 one-cycle pulses on bits 3 and 9 only, spaced 16 cycles apart; other bits stay 0; then ACTIVE.
- Timeout: LXTXPS held 0 -> FATAL after 4096 WAIT_LXTX cycles; init_err=1, P_RST_N=0, LXRXPS=0; a subsequent init_start clears init_err and re-enters RST_HOLD.
- FERR_N=0 in ALIGN in the same cycle the watchdog expires -> FATAL with init_err=1; phy_bit_slip=0 the next cycle.
- ACTIVE drop: LXTXPS deasserted while link_up=1 -> FATAL next cycle, link_up=0.
- hmc_res asserted in ALIGN mid-slip, and init_start pulsed in ACTIVE -> reset returns all outputs to reset values within one cycle; init_start in ACTIVE causes no state change.

Source files
------------

// File: rtl/hmc_link_init_ctrl.sv
// HMC link bring-up sequencer: reset hold, PHY wait, power-up, lane bit-slip alignment, active/fatal.
// All outputs registered (one cycle after the triggering event); no backpressure, inputs are level status.
module hmc_link_init_ctrl #(
    parameter int NUM_LANES    = 16,
    parameter int RST_CYCLES   = 64,
    parameter int SLIP_GAP     = 16,
    parameter int ALIGN_STABLE = 4,
    parameter int TIMEOUT      = 4096
) (
    input  logic                 hmc_clk,
    input  logic                 hmc_res,
    input  logic                 init_start,
    input  logic                 phy_tx_ready,
    input  logic                 phy_rx_ready,
    input  logic                 LXTXPS,
    input  logic                 FERR_N,
    input  logic [NUM_LANES-1:0] lane_aligned,
    output logic                 P_RST_N,
    output logic                 LXRXPS,
    output logic                 phy_init_cont_set,
    output logic [NUM_LANES-1:0] phy_bit_slip,
    output logic                 link_up,
    output logic                 init_err,
    output logic [2:0]           init_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_HOLD  = 3'd1,
        S_WAIT_PHY  = 3'd2,
        S_PWR_UP    = 3'd3,
        S_WAIT_LXTX = 3'd4,
        S_ALIGN     = 3'd5,
        S_ACTIVE    = 3'd6,
        S_FATAL     = 3'd7
    } state_t;

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int GAP_W  = (SLIP_GAP > 1) ? $clog2(SLIP_GAP) : 1;
    localparam int STAB_W = $clog2(ALIGN_STABLE + 1);
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SLIP_GAP - 1);
    localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(ALIGN_STABLE);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [STAB_W-1:0]     stab_q, stab_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  p_rst_n_q, p_rst_n_d;
    logic                  lxrxps_q, lxrxps_d;
    logic                  cont_set_q, cont_set_d;
    logic [NUM_LANES-1:0]  slip_q, slip_d;
    logic                  link_up_q, link_up_d;
    logic                  init_err_q, init_err_d;

    logic all_aligned;
    logic wd_state;
    logic wd_expired;
    logic ferr_hit;
    logic drop_hit;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        gap_d       = '0;
        stab_d      = '0;
        wd_d        = '0;
        slip_d      = '0;
        all_aligned = &lane_aligned;
        wd_state    = (state_q == S_WAIT_PHY) || (state_q == S_WAIT_LXTX) || (state_q == S_ALIGN);
        wd_expired  = wd_state && (wd_q == WD_LAST);
        ferr_hit    = !FERR_N && (state_q != S_IDLE) && (state_q != S_RST_HOLD) && (state_q != S_FATAL);
        drop_hit    = (state_q == S_ACTIVE) && (!LXTXPS || !phy_rx_ready);

        case (state_q)
            S_IDLE, S_FATAL: begin
                if (init_start) begin
                    state_d = S_RST_HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            S_RST_HOLD: begin
                if (hold_q == '0) begin
                    state_d = S_WAIT_PHY;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_WAIT_PHY: begin
                if (phy_tx_ready && phy_rx_ready) begin
                    state_d = S_PWR_UP;
                end
            end
            S_PWR_UP: begin
                state_d = S_WAIT_LXTX;
            end
            S_WAIT_LXTX: begin
                if (LXTXPS) begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                // stab_q never exceeds ALIGN_STABLE-1 here, so the increment cannot overflow
                stab_d = all_aligned ? stab_q + 1'b1 : '0;
                gap_d  = (gap_q == GAP_LAST) ? '0 : gap_q + 1'b1;
                if (stab_d == STAB_DONE) begin
                    state_d = S_ACTIVE;
                end else if (gap_q == GAP_LAST) begin
                    slip_d = ~lane_aligned;
                end
            end
            S_ACTIVE: begin
                state_d = S_ACTIVE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Error paths share one destination; their relative priority only matters against the normal move.
        if (ferr_hit || drop_hit || wd_expired) begin
            state_d = S_FATAL;
            slip_d  = '0;
        end

        if (wd_state && (state_d == state_q)) begin
            wd_d = wd_q + 1'b1;
        end

        if ((state_q != S_ALIGN) || (state_d != S_ALIGN)) begin
            gap_d  = '0;
            stab_d = '0;
        end

        p_rst_n_d  = (state_d == S_WAIT_PHY) || (state_d == S_PWR_UP) || (state_d == S_WAIT_LXTX) ||
                     (state_d == S_ALIGN) || (state_d == S_ACTIVE);
        cont_set_d = p_rst_n_d;
        lxrxps_d   = (state_d == S_WAIT_LXTX) || (state_d == S_ALIGN) || (state_d == S_ACTIVE);
        link_up_d  = (state_d == S_ACTIVE);
        // Only init_start leaves FATAL, so the error flag stays set exactly as long as FATAL does.
        init_err_d = (state_d == S_FATAL);
    end

    always_ff @(posedge hmc_clk) begin
        if (hmc_res) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            gap_q      <= '0;
            stab_q     <= '0;
            wd_q       <= '0;
            p_rst_n_q  <= 1'b0;
            lxrxps_q   <= 1'b0;
            cont_set_q <= 1'b0;
            slip_q     <= '0;
            link_up_q  <= 1'b0;
            init_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            stab_q     <= stab_d;
            wd_q       <= wd_d;
            p_rst_n_q  <= p_rst_n_d;
            lxrxps_q   <= lxrxps_d;
            cont_set_q <= cont_set_d;
            slip_q     <= slip_d;
            link_up_q  <= link_up_d;
            init_err_q <= init_err_d;
        end
    end

    assign P_RST_N           = p_rst_n_q;
    assign LXRXPS            = lxrxps_q;
    assign phy_init_cont_set = cont_set_q;
    assign phy_bit_slip      = slip_q;
    assign link_up           = link_up_q;
    assign init_err          = init_err_q;
    assign init_state        = state_q;

endmodule

// File: tb/tb_hmc_link_init_ctrl.sv
// Bench for hmc_link_init_ctrl: directed bring-up scenarios plus random traffic against a state-age model.
module tb_hmc_link_init_ctrl;

    localparam int NL = 16;
    localparam int RST_CYCLES = 64;
    localparam int SLIP_GAP = 16;
    localparam int ALIGN_STABLE = 4;
    localparam int TIMEOUT = 4096;

    logic          hmc_clk = 1'b0;
    logic          hmc_res = 1'b1;
    logic          init_start = 1'b0;
    logic          phy_tx_ready = 1'b0;
    logic          phy_rx_ready = 1'b0;
    logic          LXTXPS = 1'b0;
    logic          FERR_N = 1'b1;
    logic [NL-1:0] lane_aligned = '1;
    logic          P_RST_N;
    logic          LXRXPS;
    logic          phy_init_cont_set;
    logic [NL-1:0] phy_bit_slip;
    logic          link_up;
    logic          init_err;
    logic [2:0]    init_state;

    hmc_link_init_ctrl #(
        .NUM_LANES(NL), .RST_CYCLES(RST_CYCLES), .SLIP_GAP(SLIP_GAP),
        .ALIGN_STABLE(ALIGN_STABLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .hmc_clk(hmc_clk), .hmc_res(hmc_res), .init_start(init_start),
        .phy_tx_ready(phy_tx_ready), .phy_rx_ready(phy_rx_ready),
        .LXTXPS(LXTXPS), .FERR_N(FERR_N), .lane_aligned(lane_aligned),
        .P_RST_N(P_RST_N), .LXRXPS(LXRXPS), .phy_init_cont_set(phy_init_cont_set),
        .phy_bit_slip(phy_bit_slip), .link_up(link_up), .init_err(init_err),
        .init_state(init_state)
    );

    always #5 hmc_clk = ~hmc_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: cycle bound expired, event not seen, event required (t=%0t)", nm, $time);
    endtask

    // Lane environment: lane i reports aligned once it has received need[i] slip pulses.
    int need[NL];
    int seen[NL];
    int plast[NL];
    int pgap[NL];
    int env_gen = 0;
    int env_gen_seen = 0;
    int cyc = 0;
    bit [NL-1:0] stuck = '0;

    initial for (int i = 0; i < NL; i++) begin
        need[i] = 0; seen[i] = 0; plast[i] = 0; pgap[i] = 0;
    end

    always @(negedge hmc_clk) begin
        cyc++;
        for (int i = 0; i < NL; i++) begin
            if (env_gen != env_gen_seen) begin
                seen[i] = 0;
                pgap[i] = 0;
            end else if (phy_bit_slip[i] === 1'b1) begin
                if (seen[i] > 0) pgap[i] = cyc - plast[i];
                plast[i] = cyc;
                seen[i]++;
            end
            lane_aligned[i] = !stuck[i] && (seen[i] >= need[i]);
        end
        env_gen_seen = env_gen;
    end

    // Model: phase number plus cycles spent in the phase; every counter in the design is a function of that age.
    int m_st = 0;
    int m_age = 0;
    int m_run = 0;
    logic [NL-1:0] e_slip = '0;

    always @(posedge hmc_clk) begin
        int nst;
        int rn;
        logic [NL-1:0] sl;
        sl = '0;
        rn = 0;
        if (hmc_res) begin
            m_st = 0; m_age = 0; m_run = 0;
        end else begin
            nst = m_st;
            case (m_st)
                0, 7: if (init_start) nst = 1;
                1: if (m_age == RST_CYCLES - 1) nst = 2;
                2: if (phy_tx_ready && phy_rx_ready) nst = 3;
                3: nst = 4;
                4: if (LXTXPS) nst = 5;
                5: begin
                    rn = (&lane_aligned) ? m_run + 1 : 0;
                    if (rn >= ALIGN_STABLE) nst = 6;
                    else if (m_age % SLIP_GAP == SLIP_GAP - 1) sl = ~lane_aligned;
                end
                default: ;
            endcase
            if ((m_st == 2 || m_st == 4 || m_st == 5) && m_age >= TIMEOUT - 1) nst = 7;
            if (m_st == 6 && (!LXTXPS || !phy_rx_ready)) nst = 7;
            if (!FERR_N && m_st >= 2 && m_st <= 6) nst = 7;
            if (nst == 7) sl = '0;
            m_run = (m_st == 5 && nst == 5) ? rn : 0;
            m_age = (nst == m_st) ? m_age + 1 : 0;
            m_st = nst;
        end
        e_slip = sl;
    end

    always @(negedge hmc_clk) begin
        if (chk_en) begin
            chk("state", 32'(init_state), 32'(m_st));
            chk("p_rst_n", 32'(P_RST_N), 32'(m_st >= 2 && m_st <= 6));
            chk("cont_set", 32'(phy_init_cont_set), 32'(m_st >= 2 && m_st <= 6));
            chk("lxrxps", 32'(LXRXPS), 32'(m_st >= 4 && m_st <= 6));
            chk("link_up", 32'(link_up), 32'(m_st == 6));
            chk("init_err", 32'(init_err), 32'(m_st == 7));
            chk("bit_slip", 32'(phy_bit_slip), 32'(e_slip));
        end
    end

    task automatic tick();
        @(posedge hmc_clk);
        #1;
    endtask

    task automatic pulse_start();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int k;
        k = 0;
        while (init_state !== s && k < budget) begin
            tick();
            k++;
        end
        if (init_state !== s) bound_fail(nm);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        int others;

        // Reset values
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_state", 32'(init_state), 0);
        chk("rst_p_rst_n", 32'(P_RST_N), 0);
        chk("rst_lxrxps", 32'(LXRXPS), 0);
        chk("rst_link_up", 32'(link_up), 0);
        chk("rst_init_err", 32'(init_err), 0);
        chk("rst_slip", 32'(phy_bit_slip), 0);
        hmc_res = 1'b0;
        tick();

        // Nominal bring-up
        pulse_start();
        cnt = 0;
        while (P_RST_N === 1'b0 && cnt < 200) begin
            cnt++;
            tick();
        end
        chk("prst_low_cycles", cnt, 64);
        repeat (35) tick();
        phy_tx_ready = 1'b1;
        phy_rx_ready = 1'b1;
        cnt = 0;
        while (LXRXPS !== 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        if (LXRXPS !== 1'b1) bound_fail("nom_lxrxps");
        repeat (20) tick();
        LXTXPS = 1'b1;
        wait_state(3'd5, 50, "nom_align");
        cnt = 0;
        while (link_up !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("align_to_link", cnt, 4);
        others = 0;
        for (int i = 0; i < NL; i++) others += seen[i];
        chk("nom_slip_total", others, 0);
        chk("model_active", m_st, 6);

        // init_start ignored in ACTIVE, then LXTXPS drop
        pulse_start();
        chk("start_in_active", 32'(init_state), 6);
        LXTXPS = 1'b0;
        tick();
        chk("drop_state", 32'(init_state), 7);
        chk("drop_link_up", 32'(link_up), 0);
        chk("drop_init_err", 32'(init_err), 1);

        // Lanes 3 and 9 need two slips each
        need[3] = 2;
        need[9] = 2;
        env_gen++;
        pulse_start();
        wait_state(3'd4, 200, "slip_wait_lxtx");
        LXTXPS = 1'b1;
        wait_state(3'd6, 300, "slip_active");
        chk("slip_cnt_3", seen[3], 2);
        chk("slip_cnt_9", seen[9], 2);
        chk("slip_gap_3", pgap[3], SLIP_GAP);
        chk("slip_gap_9", pgap[9], SLIP_GAP);
        others = 0;
        for (int i = 0; i < NL; i++) if (i != 3 && i != 9) others += seen[i];
        chk("slip_other_lanes", others, 0);

        // WAIT_LXTX watchdog
        LXTXPS = 1'b0;
        tick();
        pulse_start();
        wait_state(3'd4, 200, "to_wait_lxtx");
        cnt = 0;
        while (init_state === 3'd4 && cnt < 5000) begin
            cnt++;
            tick();
        end
        chk("lxtx_timeout_cycles", cnt, TIMEOUT);
        chk("to_state", 32'(init_state), 7);
        chk("to_init_err", 32'(init_err), 1);
        chk("to_p_rst_n", 32'(P_RST_N), 0);
        chk("to_lxrxps", 32'(LXRXPS), 0);
        pulse_start();
        chk("restart_err_clr", 32'(init_err), 0);
        chk("restart_state", 32'(init_state), 1);

        // FERR_N in the same cycle the ALIGN watchdog expires, on a slip opportunity
        stuck[0] = 1'b1;
        LXTXPS = 1'b1;
        wait_state(3'd5, 300, "ferr_align");
        repeat (TIMEOUT - 1) tick();
        chk("ferr_pre_state", 32'(init_state), 5);
        FERR_N = 1'b0;
        tick();
        FERR_N = 1'b1;
        chk("ferr_state", 32'(init_state), 7);
        chk("ferr_init_err", 32'(init_err), 1);
        chk("ferr_slip", 32'(phy_bit_slip), 0);

        // Reset in the middle of slipping
        stuck = '0;
        need[5] = 3;
        env_gen++;
        pulse_start();
        cnt = 0;
        while (phy_bit_slip === '0 && cnt < 400) begin
            cnt++;
            tick();
        end
        if (phy_bit_slip === '0) bound_fail("midslip_pulse");
        hmc_res = 1'b1;
        tick();
        hmc_res = 1'b0;
        chk("midrst_state", 32'(init_state), 0);
        chk("midrst_slip", 32'(phy_bit_slip), 0);
        chk("midrst_p_rst_n", 32'(P_RST_N), 0);
        chk("midrst_lxrxps", 32'(LXRXPS), 0);

        // Random traffic, checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            init_start = ($urandom_range(0, 39) == 0);
            if (init_start) begin
                for (int i = 0; i < NL; i++)
                    need[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                env_gen++;
            end
            phy_tx_ready = ($urandom_range(0, 15) != 0);
            phy_rx_ready = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 29) == 0) LXTXPS = !LXTXPS;
            FERR_N = ($urandom_range(0, 199) != 0);
            hmc_res = ($urandom_range(0, 299) == 0);
            tick();
        end
        init_start = 1'b0;
        hmc_res = 1'b0;
        FERR_N = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
